// File: rtl/core_featuremap_conv2d_1_out_sched.sv
// Output scheduler for conv2d_1: merges NUM_FILTERS filter-core streams into one output FIFO.
// Optional stall/hold statistics counters are enabled with CONV2D1_OUT_SCHED_STATS_EN.
module core_featuremap_conv2d_1_out_sched #(
  parameter int DWIDTH      = 32,
  parameter int NUM_FILTERS = 4,
  parameter int BUF_DEPTH   = 4,
  parameter int HOLD_MARGIN = 2,
  localparam int GW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_FILTERS*DWIDTH-1:0] f_wdata,
  input  logic [NUM_FILTERS-1:0]        f_wrreq,
  output logic                          core_hold,
  output logic [DWIDTH-1:0]             ff_wdata,
  output logic                          ff_wrreq,
  input  logic                          ff_full,
  output logic [NUM_FILTERS-1:0]        ovf_flag,
  output logic [GW-1:0]                 last_grant
`ifdef CONV2D1_OUT_SCHED_STATS_EN
  ,
  output logic [31:0]                   stall_cnt,
  output logic [31:0]                   hold_cnt
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] HOLD_LVL = CW'(BUF_DEPTH - HOLD_MARGIN);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_BLOCKED = 2'd2;

  logic [NUM_FILTERS-1:0]             nonempty;
  logic [NUM_FILTERS-1:0]             hold_req;
  logic [NUM_FILTERS-1:0]             pop_vec;
  logic [NUM_FILTERS-1:0]             ovf_reg;
  logic [NUM_FILTERS-1:0][DWIDTH-1:0] head_data;

  logic [1:0]        arb_state;
  logic              pop_any;
  logic              found;
  logic [GW-1:0]     cand;
  logic [GW-1:0]     grant_idx;
  logic [GW-1:0]     rr_ptr_reg;
  logic              ff_wrreq_reg;
  logic [DWIDTH-1:0] ff_wdata_reg;
  logic [GW-1:0]     last_grant_reg;
  logic              core_hold_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FILTERS; gi++) begin : g_buf
      logic [DWIDTH-1:0] mem [BUF_DEPTH];
      logic [PW-1:0]     wr_ptr_reg;
      logic [PW-1:0]     rd_ptr_reg;
      logic [CW-1:0]     cnt_reg;
      logic              ovf_bit_reg;
      logic              is_full;
      logic              push_ok;

      // A full buffer still accepts a word when its head leaves in the same cycle.
      assign is_full        = (cnt_reg == FULL_LVL);
      assign push_ok        = f_wrreq[gi] && (!is_full || pop_vec[gi]);
      assign nonempty[gi]   = (cnt_reg != '0);
      assign hold_req[gi]   = (cnt_reg >= HOLD_LVL);
      assign head_data[gi]  = mem[rd_ptr_reg];
      assign ovf_reg[gi]    = ovf_bit_reg;

      always_ff @(posedge clock) begin
        if (push_ok) begin
          mem[wr_ptr_reg] <= f_wdata[gi*DWIDTH +: DWIDTH];
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          wr_ptr_reg  <= '0;
          rd_ptr_reg  <= '0;
          cnt_reg     <= '0;
          ovf_bit_reg <= 1'b0;
        end else begin
          if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
          end
          if (pop_vec[gi]) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
          end
          if (push_ok && !pop_vec[gi]) begin
            cnt_reg <= cnt_reg + 1'b1;
          end else if (!push_ok && pop_vec[gi]) begin
            cnt_reg <= cnt_reg - 1'b1;
          end
          if (f_wrreq[gi] && !push_ok) begin
            ovf_bit_reg <= 1'b1;
          end
        end
      end
    end
  endgenerate

  // Round-robin search begins one past the last granted filter.
  always_comb begin
    found     = 1'b0;
    cand      = '0;
    grant_idx = '0;
    for (int k = 0; k < NUM_FILTERS; k++) begin
      cand = GW'((int'(rr_ptr_reg) + 1 + k) % NUM_FILTERS);
      if (!found && nonempty[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end

    if (!found) begin
      arb_state = ST_IDLE;
    end else if (ff_full) begin
      arb_state = ST_BLOCKED;
    end else begin
      arb_state = ST_GRANT;
    end

    pop_any = (arb_state == ST_GRANT);
    pop_vec = '0;
    if (pop_any) begin
      pop_vec[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ff_wrreq_reg   <= 1'b0;
      ff_wdata_reg   <= '0;
      last_grant_reg <= '0;
      core_hold_reg  <= 1'b0;
      rr_ptr_reg     <= GW'(NUM_FILTERS - 1);
    end else begin
      ff_wrreq_reg  <= pop_any;
      core_hold_reg <= |hold_req;
      if (pop_any) begin
        ff_wdata_reg   <= head_data[grant_idx];
        last_grant_reg <= grant_idx;
        rr_ptr_reg     <= grant_idx;
      end
    end
  end

  assign ff_wrreq   = ff_wrreq_reg;
  assign ff_wdata   = ff_wdata_reg;
  assign last_grant = last_grant_reg;
  assign core_hold  = core_hold_reg;
  assign ovf_flag   = ovf_reg;

`ifdef CONV2D1_OUT_SCHED_STATS_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] hold_cnt_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg <= '0;
      hold_cnt_reg  <= '0;
    end else begin
      if ((arb_state == ST_BLOCKED) && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if (core_hold_reg && (hold_cnt_reg != '1)) begin
        hold_cnt_reg <= hold_cnt_reg + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign hold_cnt  = hold_cnt_reg;
`endif

endmodule

// File: tb/tb_core_featuremap_conv2d_1_out_sched.sv
// Directed self-checking bench for core_featuremap_conv2d_1_out_sched (default parameters).
module tb_core_featuremap_conv2d_1_out_sched;

  localparam int DW = 32;
  localparam int NF = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [NF*DW-1:0] f_wdata = '0;
  logic [NF-1:0]    f_wrreq = '0;
  logic             ff_full = 1'b0;
  logic             core_hold;
  logic [DW-1:0]    ff_wdata;
  logic             ff_wrreq;
  logic [NF-1:0]    ovf_flag;
  logic [1:0]       last_grant;
`ifdef CONV2D1_OUT_SCHED_STATS_EN
  logic [31:0]      stall_cnt;
  logic [31:0]      hold_cnt;
`endif

  core_featuremap_conv2d_1_out_sched #(
    .DWIDTH(DW), .NUM_FILTERS(NF), .BUF_DEPTH(4), .HOLD_MARGIN(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .f_wdata(f_wdata),
    .f_wrreq(f_wrreq),
    .core_hold(core_hold),
    .ff_wdata(ff_wdata),
    .ff_wrreq(ff_wrreq),
    .ff_full(ff_full),
    .ovf_flag(ovf_flag),
    .last_grant(last_grant)
`ifdef CONV2D1_OUT_SCHED_STATS_EN
    ,
    .stall_cnt(stall_cnt),
    .hold_cnt(hold_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] got_data[$];
  int          got_grant[$];

  // Capture every output-FIFO write just after the edge that produced it.
  always @(posedge clock) begin
    #1;
    if (reset && ff_wrreq) begin
      got_data.push_back(ff_wdata);
      got_grant.push_back(int'(last_grant));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("check %s ok (0x%08h)", tag, got);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    f_wrreq = '0;
    ff_full = 1'b0;
    tick(2);
    reset = 1'b1;
    got_data.delete();
    got_grant.delete();
  endtask

  task automatic set_word(input int f, input logic [31:0] w);
    f_wdata[f*DW +: DW] = w;
    f_wrreq[f] = 1'b1;
  endtask

  task automatic wait_words(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (got_data.size() < n && c < budget) begin
      tick();
      c++;
    end
    check(tag, got_data.size(), n);
  endtask

  logic [31:0] exp_w;
  int sent [NF];
  int hold_hist [4];
  int wr_seen;
  int mism;
  int n;

  initial begin
    // Reset state
    tick(2);
    check("rst_wrreq", ff_wrreq, 0);
    check("rst_wdata", ff_wdata, 0);
    check("rst_hold", core_hold, 0);
    check("rst_ovf", ovf_flag, 0);
    check("rst_grant", last_grant, 0);
    reset = 1'b1;
    tick();

    // Single word on filter 2: two-edge latency, one-cycle strobe
    set_word(2, 32'hA5A5_0001);
    tick();
    f_wrreq = '0;
    check("t1_wrreq_edge1", ff_wrreq, 0);
    tick();
    check("t1_wrreq_edge2", ff_wrreq, 1);
    check("t1_wdata", ff_wdata, 32'hA5A5_0001);
    check("t1_grant", last_grant, 2);
    tick();
    check("t1_wrreq_drop", ff_wrreq, 0);
    check("t1_wdata_hold", ff_wdata, 32'hA5A5_0001);

    // All filters stream 8 words each, obeying core_hold
    do_reset();
    for (int f = 0; f < NF; f++) sent[f] = 0;
    for (int k = 1; k <= 60; k++) begin
      f_wrreq = '0;
      if (!core_hold) begin
        for (int f = 0; f < NF; f++) begin
          if (sent[f] < 8) begin
            set_word(f, 32'hF000_0000 | (32'(f) << 8) | 32'(sent[f]));
            sent[f]++;
          end
        end
      end
      tick();
      if (k <= 3) hold_hist[k] = int'(core_hold);
    end
    f_wrreq = '0;
    wait_words("t2_count", 32, 20);
    check("t2_hold_e1", hold_hist[1], 0);
    check("t2_hold_e2", hold_hist[2], 0);
    check("t2_hold_e3", hold_hist[3], 1);
    check("t2_ovf", ovf_flag, 0);
    for (int i = 0; i < 32 && i < got_data.size(); i++) begin
      check($sformatf("t2_grant_%0d", i), got_grant[i], i % 4);
      check($sformatf("t2_data_%0d", i), got_data[i],
            32'hF000_0000 | (32'(i % 4) << 8) | 32'(i / 4));
    end

    // Output FIFO full for 10 cycles while filter 0 pushes 5 words
    do_reset();
    set_word(0, 32'hB000_0000);
    tick();
    ff_full = 1'b1;
    wr_seen = 0;
    for (int j = 1; j <= 10; j++) begin
      f_wrreq = '0;
      if (j <= 4) set_word(0, 32'hB000_0000 | 32'(j));
      tick();
      if (ff_wrreq) wr_seen++;
    end
    f_wrreq = '0;
    check("t3_no_wr_full", wr_seen, 0);
    check("t3_ovf", ovf_flag, 4'b0001);
`ifdef CONV2D1_OUT_SCHED_STATS_EN
    check("t3_stall_cnt", stall_cnt, 10);
`endif
    ff_full = 1'b0;
    tick(12);
    check("t3_count", got_data.size(), 4);
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      check($sformatf("t3_data_%0d", i), got_data[i], 32'hB000_0000 | 32'(i));
    end
`ifdef CONV2D1_OUT_SCHED_STATS_EN
    check("t3_hold_cnt", hold_cnt, 12);
`endif

    // Filter 1 full, push and pop in the same cycle
    do_reset();
    ff_full = 1'b1;
    for (int j = 0; j < 4; j++) begin
      f_wrreq = '0;
      set_word(1, 32'h1100_0000 | 32'(j));
      tick();
    end
    ff_full = 1'b0;
    f_wrreq = '0;
    set_word(1, 32'h1100_0004);
    tick();
    f_wrreq = '0;
    check("t4_ovf", ovf_flag, 0);
    tick(10);
    check("t4_count", got_data.size(), 5);
    for (int i = 0; i < 5 && i < got_data.size(); i++) begin
      check($sformatf("t4_data_%0d", i), got_data[i], 32'h1100_0000 | 32'(i));
    end

    // Reset while three buffers hold data
    do_reset();
    set_word(0, 32'h5555_0001);
    tick();
    f_wrreq = '0;
    tick(2);
    ff_full = 1'b1;
    for (int j = 0; j < 3; j++) begin
      f_wrreq = '0;
      for (int f = 0; f < 3; f++) set_word(f, 32'h7700_0000 | (32'(f) << 8) | 32'(j));
      tick();
    end
    f_wrreq = '0;
    check("t5_pre_hold", core_hold, 1);
    check("t5_pre_wdata", ff_wdata, 32'h5555_0001);
    reset = 1'b0;
    #1;
    check("t5_rst_wrreq", ff_wrreq, 0);
    check("t5_rst_wdata", ff_wdata, 0);
    check("t5_rst_hold", core_hold, 0);
    check("t5_rst_grant", last_grant, 0);
    tick();
    ff_full = 1'b0;
    reset = 1'b1;
    got_data.delete();
    got_grant.delete();
    tick(10);
    check("t5_no_stale", got_data.size(), 0);

    // rr_ptr at 0: filter 3 wins over filter 0, then strict alternation
    do_reset();
    set_word(0, 32'hC0FF_FFFF);
    tick();
    f_wrreq = '0;
    tick(3);
    got_data.delete();
    got_grant.delete();
    n = 0;
    for (int k = 0; k < 100; k++) begin
      f_wrreq = '0;
      if (k % 2 == 0) begin
        set_word(0, 32'hC000_0000 | 32'(n));
        set_word(3, 32'hD000_0000 | 32'(n));
        n++;
      end
      tick();
    end
    f_wrreq = '0;
    wait_words("t6_count", 100, 10);
    if (got_grant.size() > 0) check("t6_first_grant", got_grant[0], 3);
    mism = 0;
    for (int i = 0; i < got_data.size(); i++) begin
      exp_w = ((i % 2 == 0) ? 32'hD000_0000 : 32'hC000_0000) | 32'(i / 2);
      if (got_grant[i] != ((i % 2 == 0) ? 3 : 0) || got_data[i] != exp_w) mism++;
    end
    check("t6_order_mismatches", mism, 0);
    check("t6_ovf", ovf_flag, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
